// File: rtl/xalu_ise_pkg.sv
// Shared constants and state encoding for the xalu_ise arbiter slice.
package xalu_ise_pkg;

  localparam int FN_W  = 6;
  localparam int IMM_W = 7;
  localparam int XLEN  = 32;

  localparam logic [1:0] CUSTOM_0 = 2'd0;
  localparam logic [1:0] CUSTOM_1 = 2'd1;
  localparam logic [1:0] CUSTOM_2 = 2'd2;
  localparam logic [1:0] CUSTOM_3 = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ise_state_t;

endpackage

// File: rtl/xalu_ise_rr2.sv
// Two-way arbiter: combinational grant, registered last-owner pointer.
module xalu_ise_rr2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       rr_en,
  output logic [1:0] gnt,
  output logic       owner
);

  always_comb begin
    gnt = '0;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // Tie: round-robin favours the requester that did not own last.
        2'b11:   gnt = (rr_en && !owner) ? 2'b10 : 2'b01;
        default: gnt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= 1'b1;
    end else if (|gnt) begin
      owner <= gnt[1];
    end
  end

endmodule

// File: rtl/xalu_ise_arb.sv
// Arbiter/sequencer sharing one xalu_ise datapath between two requesters.
module xalu_ise_arb
  import xalu_ise_pkg::*;
#(
  parameter bit RR_EN = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             ise_clk,
  input  logic             ise_rst,
  input  logic             r0_req,
  output logic             r0_gnt,
  input  logic [FN_W-1:0]  r0_fn,
  input  logic [IMM_W-1:0] r0_imm,
  input  logic [XLEN-1:0]  r0_in1,
  input  logic [XLEN-1:0]  r0_in2,
  output logic             r0_rsp_val,
  input  logic             r0_rsp_rdy,
  output logic [XLEN-1:0]  r0_rsp_out,
  output logic             r0_rsp_err,
  input  logic             r1_req,
  output logic             r1_gnt,
  input  logic [FN_W-1:0]  r1_fn,
  input  logic [IMM_W-1:0] r1_imm,
  input  logic [XLEN-1:0]  r1_in1,
  input  logic [XLEN-1:0]  r1_in2,
  output logic             r1_rsp_val,
  input  logic             r1_rsp_rdy,
  output logic [XLEN-1:0]  r1_rsp_out,
  output logic             r1_rsp_err,
  output logic [FN_W-1:0]  dp_fn,
  output logic [IMM_W-1:0] dp_imm,
  output logic [XLEN-1:0]  dp_in1,
  output logic [XLEN-1:0]  dp_in2,
  output logic             dp_val,
  input  logic             dp_oval,
  input  logic [XLEN-1:0]  dp_out,
  output logic             busy,
  output logic [CNT_W-1:0] ops_cnt
);

  ise_state_t       state;
  logic [1:0]       gnt;
  logic             owner;
  logic             own_rdy;
  logic             rsp_hs;
  logic             arb_en;
  logic             accept;
  logic [FN_W-1:0]  fn_q;
  logic [IMM_W-1:0] imm_q;
  logic [XLEN-1:0]  in1_q;
  logic [XLEN-1:0]  in2_q;
  logic [XLEN-1:0]  res_q;
  logic             err_q;

  assign own_rdy = owner ? r1_rsp_rdy : r0_rsp_rdy;
  assign rsp_hs  = (state == RESP) && own_rdy;
  // Granting during the RESP handshake gives back-to-back issue.
  assign arb_en  = (state == IDLE) || rsp_hs;
  assign accept  = |gnt;

  xalu_ise_rr2 u_rr2 (
    .clk   (ise_clk),
    .rst_n (ise_rst),
    .req   ({r1_req, r0_req}),
    .en    (arb_en),
    .rr_en (RR_EN),
    .gnt   (gnt),
    .owner (owner)
  );

  assign r0_gnt = gnt[0];
  assign r1_gnt = gnt[1];

  always_ff @(posedge ise_clk or negedge ise_rst) begin
    if (!ise_rst) begin
      state   <= IDLE;
      fn_q    <= '0;
      imm_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      ops_cnt <= '0;
    end else begin
      if (accept) begin
        fn_q  <= gnt[1] ? r1_fn  : r0_fn;
        imm_q <= gnt[1] ? r1_imm : r0_imm;
        in1_q <= gnt[1] ? r1_in1 : r0_in1;
        in2_q <= gnt[1] ? r1_in2 : r0_in2;
      end
      case (state)
        IDLE: begin
          if (accept) state <= EXEC;
        end
        EXEC: begin
          res_q <= dp_oval ? dp_out : '0;
          err_q <= ~dp_oval;
          state <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            ops_cnt <= ops_cnt + CNT_W'(1);
            state   <= accept ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign dp_val = (state == EXEC);
  assign dp_fn  = dp_val ? fn_q  : '0;
  assign dp_imm = dp_val ? imm_q : '0;
  assign dp_in1 = dp_val ? in1_q : '0;
  assign dp_in2 = dp_val ? in2_q : '0;

  assign r0_rsp_val = (state == RESP) && !owner;
  assign r1_rsp_val = (state == RESP) &&  owner;
  assign r0_rsp_out = owner ? '0 : res_q;
  assign r1_rsp_out = owner ? res_q : '0;
  assign r0_rsp_err = !owner && err_q;
  assign r1_rsp_err =  owner && err_q;

endmodule

// File: tb/tb_xalu_ise_arb.sv
// Directed self-checking bench for xalu_ise_arb (round-robin and fixed-priority builds).
module tb_xalu_ise_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r1_req, r0_rsp_rdy, r1_rsp_rdy;
  logic [5:0]  r0_fn, r1_fn;
  logic [6:0]  r0_imm, r1_imm;
  logic [31:0] r0_in1, r0_in2, r1_in1, r1_in2;
  logic        fix_oval;
  logic [31:0] fix_out;

  logic        r0_gnt, r1_gnt, r0_rsp_val, r1_rsp_val, r0_rsp_err, r1_rsp_err;
  logic [31:0] r0_rsp_out, r1_rsp_out, dp_in1, dp_in2;
  logic [5:0]  dp_fn;
  logic [6:0]  dp_imm;
  logic        dp_val, busy;
  logic [15:0] ops_cnt;

  logic        b_r0_req, b_r1_req;
  logic        b_r0_gnt, b_r1_gnt, b_r0_rsp_val, b_r1_rsp_val, b_r0_rsp_err, b_r1_rsp_err;
  logic [31:0] b_r0_rsp_out, b_r1_rsp_out, b_dp_in1, b_dp_in2;
  logic [5:0]  b_dp_fn;
  logic [6:0]  b_dp_imm;
  logic        b_dp_val, b_busy;
  logic [1:0]  b_ops;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  xalu_ise_arb #(.RR_EN(1'b1), .CNT_W(16)) dut (
    .ise_clk(clk), .ise_rst(rst_n),
    .r0_req(r0_req), .r0_gnt(r0_gnt), .r0_fn(r0_fn), .r0_imm(r0_imm),
    .r0_in1(r0_in1), .r0_in2(r0_in2), .r0_rsp_val(r0_rsp_val), .r0_rsp_rdy(r0_rsp_rdy),
    .r0_rsp_out(r0_rsp_out), .r0_rsp_err(r0_rsp_err),
    .r1_req(r1_req), .r1_gnt(r1_gnt), .r1_fn(r1_fn), .r1_imm(r1_imm),
    .r1_in1(r1_in1), .r1_in2(r1_in2), .r1_rsp_val(r1_rsp_val), .r1_rsp_rdy(r1_rsp_rdy),
    .r1_rsp_out(r1_rsp_out), .r1_rsp_err(r1_rsp_err),
    .dp_fn(dp_fn), .dp_imm(dp_imm), .dp_in1(dp_in1), .dp_in2(dp_in2), .dp_val(dp_val),
    .dp_oval(fix_oval), .dp_out(fix_out), .busy(busy), .ops_cnt(ops_cnt)
  );

  xalu_ise_arb #(.RR_EN(1'b0), .CNT_W(2)) dut_b (
    .ise_clk(clk), .ise_rst(rst_n),
    .r0_req(b_r0_req), .r0_gnt(b_r0_gnt), .r0_fn(r0_fn), .r0_imm(r0_imm),
    .r0_in1(r0_in1), .r0_in2(r0_in2), .r0_rsp_val(b_r0_rsp_val), .r0_rsp_rdy(1'b1),
    .r0_rsp_out(b_r0_rsp_out), .r0_rsp_err(b_r0_rsp_err),
    .r1_req(b_r1_req), .r1_gnt(b_r1_gnt), .r1_fn(r1_fn), .r1_imm(r1_imm),
    .r1_in1(r1_in1), .r1_in2(r1_in2), .r1_rsp_val(b_r1_rsp_val), .r1_rsp_rdy(1'b1),
    .r1_rsp_out(b_r1_rsp_out), .r1_rsp_err(b_r1_rsp_err),
    .dp_fn(b_dp_fn), .dp_imm(b_dp_imm), .dp_in1(b_dp_in1), .dp_in2(b_dp_in2), .dp_val(b_dp_val),
    .dp_oval(1'b1), .dp_out(fix_out), .busy(b_busy), .ops_cnt(b_ops)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    r0_req = 1'b0; r1_req = 1'b0; b_r0_req = 1'b0; b_r1_req = 1'b0;
    r0_rsp_rdy = 1'b1; r1_rsp_rdy = 1'b1;
    r0_fn = '0; r1_fn = '0; r0_imm = '0; r1_imm = '0;
    r0_in1 = '0; r0_in2 = '0; r1_in1 = '0; r1_in2 = '0;
    fix_oval = 1'b1; fix_out = '0;

    // Reset state
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gnt", 32'({r1_gnt, r0_gnt}), 0);
    chk("rst_rsp_val", 32'({r1_rsp_val, r0_rsp_val}), 0);
    chk("rst_dp_val", 32'(dp_val), 0);
    chk("rst_dp_in1", dp_in1, 0);
    chk("rst_ops", 32'(ops_cnt), 0);
    chk("rst_rsp_out", r0_rsp_out | r1_rsp_out, 0);
    mid();
    rst_n = 1'b1;

    // Single op from r0
    step();
    r0_req = 1'b1; r0_fn = 6'b000001; r0_imm = '0;
    r0_in1 = 32'hA5A5A5A5; r0_in2 = 32'h0F0F0F0F;
    fix_oval = 1'b1; fix_out = 32'h12345678;
    mid();
    chk("t1_r0_gnt", 32'(r0_gnt), 1);
    chk("t1_r1_gnt", 32'(r1_gnt), 0);
    chk("t1_dp_val_t0", 32'(dp_val), 0);
    step();
    r0_req = 1'b0; r0_fn = '0; r0_in1 = '0; r0_in2 = '0;
    mid();
    chk("t1_dp_val_t1", 32'(dp_val), 1);
    chk("t1_dp_fn", 32'(dp_fn), 1);
    chk("t1_dp_in1", dp_in1, 32'hA5A5A5A5);
    chk("t1_dp_in2", dp_in2, 32'h0F0F0F0F);
    chk("t1_rsp_val_t1", 32'(r0_rsp_val), 0);
    step();
    mid();
    chk("t1_rsp_val_t2", 32'(r0_rsp_val), 1);
    chk("t1_rsp_out", r0_rsp_out, 32'h12345678);
    chk("t1_rsp_err", 32'(r0_rsp_err), 0);
    chk("t1_r1_rsp_val", 32'(r1_rsp_val), 0);
    chk("t1_dp_val_t2", 32'(dp_val), 0);
    step();
    mid();
    chk("t1_ops", 32'(ops_cnt), 1);
    chk("t1_busy", 32'(busy), 0);

    // Unsupported encoding from r1
    step();
    r1_req = 1'b1; r1_fn = 6'b000011; r1_in1 = 32'd1; r1_in2 = 32'd2;
    fix_oval = 1'b0; fix_out = 32'hFFFFFFFF;
    mid();
    chk("t2_r1_gnt", 32'(r1_gnt), 1);
    chk("t2_r0_rsp_val_a", 32'(r0_rsp_val), 0);
    step();
    r1_req = 1'b0;
    mid();
    chk("t2_dp_fn", 32'(dp_fn), 3);
    chk("t2_r0_rsp_val_b", 32'(r0_rsp_val), 0);
    step();
    mid();
    chk("t2_r1_rsp_val", 32'(r1_rsp_val), 1);
    chk("t2_r1_rsp_out", r1_rsp_out, 0);
    chk("t2_r1_rsp_err", 32'(r1_rsp_err), 1);
    chk("t2_r0_rsp_val_c", 32'(r0_rsp_val), 0);
    chk("t2_r0_rsp_nonown", 32'({r0_rsp_out[0], r0_rsp_err}) | r0_rsp_out, 0);
    step();
    mid();
    chk("t2_ops", 32'(ops_cnt), 2);

    // Round-robin contention, six grants
    fix_oval = 1'b1; fix_out = 32'hCAFE0000;
    r0_fn = 6'd1; r1_fn = 6'd2;
    for (int c = 0; c <= 12; c++) begin
      step();
      r0_req = (c <= 10); r1_req = (c <= 10);
      mid();
      chk($sformatf("rr_gnt0_c%0d", c), 32'(r0_gnt), 32'((c % 4 == 0) && c <= 10));
      chk($sformatf("rr_gnt1_c%0d", c), 32'(r1_gnt), 32'((c % 4 == 2) && c <= 10));
      if (c % 2 == 1) chk($sformatf("rr_dp_fn_c%0d", c), 32'(dp_fn), (c % 4 == 1) ? 1 : 2);
    end
    step();
    mid();
    chk("rr_ops", 32'(ops_cnt), 8);
    chk("rr_busy", 32'(busy), 0);

    // Backpressure on r0 while r1 waits
    step();
    r0_req = 1'b1; r0_rsp_rdy = 1'b0; fix_out = 32'h5A5A0001;
    mid();
    chk("bp_r0_gnt", 32'(r0_gnt), 1);
    step();
    r0_req = 1'b0; r1_req = 1'b1;
    mid();
    chk("bp_dp_val", 32'(dp_val), 1);
    chk("bp_r1_gnt_exec", 32'(r1_gnt), 0);
    for (int k = 0; k < 5; k++) begin
      step();
      fix_out = 32'hDEADBEEF;
      mid();
      chk($sformatf("bp_rsp_val_k%0d", k), 32'(r0_rsp_val), 1);
      chk($sformatf("bp_rsp_out_k%0d", k), r0_rsp_out, 32'h5A5A0001);
      chk($sformatf("bp_r1_gnt_k%0d", k), 32'(r1_gnt), 0);
    end
    step();
    r0_rsp_rdy = 1'b1;
    mid();
    chk("bp_r1_gnt_rel", 32'(r1_gnt), 1);
    chk("bp_rsp_val_rel", 32'(r0_rsp_val), 1);
    chk("bp_dp_val_rel", 32'(dp_val), 0);
    step();
    r1_req = 1'b0;
    mid();
    chk("bp_dp_val_next", 32'(dp_val), 1);
    chk("bp_dp_fn_next", 32'(dp_fn), 2);
    step();
    mid();
    chk("bp_r1_rsp_val", 32'(r1_rsp_val), 1);
    chk("bp_r1_rsp_out", r1_rsp_out, 32'hDEADBEEF);
    step();
    mid();
    chk("bp_ops", 32'(ops_cnt), 10);

    // Asynchronous reset during EXEC
    fix_out = 32'h00C0FFEE;
    step();
    r0_req = 1'b1;
    mid();
    chk("ar_r0_gnt", 32'(r0_gnt), 1);
    step();
    r0_req = 1'b0;
    mid();
    chk("ar_dp_val_pre", 32'(dp_val), 1);
    chk("ar_busy_pre", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_dp_val", 32'(dp_val), 0);
    chk("ar_gnt", 32'({r1_gnt, r0_gnt}), 0);
    chk("ar_rsp_val", 32'({r1_rsp_val, r0_rsp_val}), 0);
    chk("ar_ops", 32'(ops_cnt), 0);
    chk("ar_dp_in1", dp_in1, 0);
    step();
    rst_n = 1'b1;
    mid();
    chk("ar_busy_rel", 32'(busy), 0);
    step();
    r1_req = 1'b1; r1_in1 = 32'd7; r1_fn = 6'd2;
    mid();
    chk("ar_r1_gnt", 32'(r1_gnt), 1);
    step();
    r1_req = 1'b0;
    mid();
    chk("ar_r1_dp_val", 32'(dp_val), 1);
    chk("ar_r1_dp_in1", dp_in1, 7);
    step();
    mid();
    chk("ar_r1_rsp_val", 32'(r1_rsp_val), 1);
    chk("ar_r1_rsp_out", r1_rsp_out, 32'h00C0FFEE);
    chk("ar_r1_rsp_err", 32'(r1_rsp_err), 0);
    step();
    mid();
    chk("ar_ops_after", 32'(ops_cnt), 1);

    // Fixed priority with 2-bit counter wrap
    for (int c = 0; c <= 11; c++) begin
      step();
      b_r0_req = (c <= 8); b_r1_req = (c <= 8);
      mid();
      chk($sformatf("fp_gnt0_c%0d", c), 32'(b_r0_gnt), 32'((c % 2 == 0) && c <= 8));
      chk($sformatf("fp_gnt1_c%0d", c), 32'(b_r1_gnt), 0);
      if (c % 2 == 1) chk($sformatf("fp_ops_c%0d", c), 32'(b_ops), ((c - 1) / 2) % 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
